// File: rtl/mdu_if.sv
// Request/result bundle between the pipeline and the multiply/divide unit.
// The pipeline drives operands and op; the unit returns busy and the HI/LO registers.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output start, op, A, B,
    input  busy, HI, LO
  );

  modport slave (
    input  start, op, A, B,
    output busy, HI, LO
  );
endinterface

// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Results are computed at acceptance and committed to HI/LO only when the busy timer expires.
module mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic  clk,
  input logic  reset,
  mdu_if.slave bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StMul  = 2'd1;
  localparam logic [1:0] StDiv  = 2'd2;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [1:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic [31:0]     res_hi_q, res_hi_d, res_lo_q, res_lo_d;
  logic            wr_q, wr_d;

  logic [63:0] prod_s, prod_u;
  logic [31:0] div_b, abs_a, abs_b, qu, ru, qs_mag, rs_mag, qs, rs;

  assign prod_s = $signed({{32{bus.A[31]}}, bus.A}) * $signed({{32{bus.B[31]}}, bus.B});
  assign prod_u = {32'd0, bus.A} * {32'd0, bus.B};

  // Divisor forced to 1 when zero keeps the dividers well-defined; the result is discarded.
  assign div_b  = (bus.B == 32'd0) ? 32'd1 : bus.B;
  assign qu     = bus.A / div_b;
  assign ru     = bus.A % div_b;

  // Magnitude-based signed divide: 0x80000000 / -1 wraps naturally to 0x80000000.
  assign abs_a  = bus.A[31] ? (32'd0 - bus.A) : bus.A;
  assign abs_b  = div_b[31] ? (32'd0 - div_b) : div_b;
  assign qs_mag = abs_a / abs_b;
  assign rs_mag = abs_a % abs_b;
  assign qs     = (bus.A[31] ^ bus.B[31]) ? (32'd0 - qs_mag) : qs_mag;
  assign rs     = bus.A[31] ? (32'd0 - rs_mag) : rs_mag;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    wr_d     = wr_q;
    case (state_q)
      StIdle: begin
        if (bus.start) begin
          case (bus.op)
            3'd0, 3'd1: begin
              res_hi_d = (bus.op == 3'd0) ? prod_s[63:32] : prod_u[63:32];
              res_lo_d = (bus.op == 3'd0) ? prod_s[31:0]  : prod_u[31:0];
              wr_d     = 1'b1;
              cnt_d    = CntW'(MULT_CYCLES);
              state_d  = StMul;
            end
            3'd2, 3'd3: begin
              res_hi_d = (bus.op == 3'd2) ? rs : ru;
              res_lo_d = (bus.op == 3'd2) ? qs : qu;
              wr_d     = (bus.B != 32'd0);
              cnt_d    = CntW'(DIV_CYCLES);
              state_d  = StDiv;
            end
            3'd4:    hi_d = bus.A;
            3'd5:    lo_d = bus.A;
            default: ;
          endcase
        end
      end
      StMul, StDiv: begin
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          cnt_d   = '0;
          if (wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      wr_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      wr_q     <= wr_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Scoreboard bench for mdu: expected HI/LO pushed on issue, popped when busy falls.
module tb_mdu;
  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mdu_if bus ();

  mdu #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  res_t        scb[$];
  logic [31:0] m_hi, m_lo;
  int          errors = 0;
  int          checks = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: 64-bit arithmetic, SV division truncates toward zero.
  function automatic void model_push(input logic [2:0] o, input logic [31:0] a,
                                     input logic [31:0] b);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      3'd0: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd1: begin p = {32'd0, a} * {32'd0, b}; m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_hi = 32'(r); m_lo = 32'(q); end
      3'd3: if (b != 32'd0) begin m_hi = a % b; m_lo = a / b; end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
      default: ;
    endcase
    if (o <= 3'd3) scb.push_back({m_hi, m_lo});
  endfunction

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    model_push(o, a, b);
    bus.start = 1'b1;
    bus.op    = o;
    bus.A     = a;
    bus.B     = b;
    tick();
    bus.start = 1'b0;
  endtask

  // Drain: HI/LO must hold while busy, busy must last exp cycles, then the popped result lands.
  task automatic wait_done(input int exp, input string name);
    logic [31:0] h0, l0;
    res_t        e;
    int          cyc;
    h0  = bus.HI;
    l0  = bus.LO;
    cyc = 0;
    while (bus.busy === 1'b1 && cyc < 200) begin
      checks++;
      if (bus.HI !== h0 || bus.LO !== l0) begin
        errors++;
        $display("FAIL %s_hold: HI=%h LO=%h required HI=%h LO=%h", name, bus.HI, bus.LO, h0, l0);
      end
      cyc++;
      tick();
    end
    checks++;
    if (cyc != exp) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d required %0d", name, cyc, exp);
    end
    checks++;
    if (scb.size() == 0) begin
      errors++;
      $display("FAIL %s_result: scoreboard empty, HI=%h LO=%h", name, bus.HI, bus.LO);
    end else begin
      e = scb.pop_front();
      if (bus.HI !== e.hi || bus.LO !== e.lo) begin
        errors++;
        $display("FAIL %s_result: HI=%h LO=%h required HI=%h LO=%h",
                 name, bus.HI, bus.LO, e.hi, e.lo);
      end
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.A     = 32'd0;
    bus.B     = 32'd0;
    tick();
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: busy=%b HI=%h LO=%h required 0 0 0", bus.busy, bus.HI, bus.LO);
    end
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    reset = 1'b0;
  endtask

  task automatic test_mult();
    issue(3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    wait_done(MC, "mult_neg");
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_neg_const: HI=%h LO=%h required FFFFFFFF FFFFFFFA", bus.HI, bus.LO);
    end
    issue(3'd1, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_done(MC, "multu");
    checks++;
    if (bus.HI !== 32'h0000_0001 || bus.LO !== 32'hFFFF_FFFE) begin
      errors++;
      $display("FAIL multu_const: HI=%h LO=%h required 00000001 FFFFFFFE", bus.HI, bus.LO);
    end
    issue(3'd0, 32'h8000_0000, 32'h8000_0000);
    wait_done(MC, "mult_min");
    for (int i = 0; i < 4; i++) begin
      issue(3'(i % 2), $urandom, $urandom);
      wait_done(MC, "mult_rand");
    end
  endtask

  task automatic test_div();
    issue(3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(DC, "div_neg");
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL div_neg_const: HI=%h LO=%h required FFFFFFFF FFFFFFFD", bus.HI, bus.LO);
    end
    issue(3'd3, 32'h1234_0000, 32'h0000_0000);
    wait_done(DC, "divu_zero");
    checks++;
    if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
      errors++;
      $display("FAIL divu_zero_const: HI=%h LO=%h required FFFFFFFF FFFFFFFD", bus.HI, bus.LO);
    end
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(DC, "div_ovf");
    checks++;
    if (bus.HI !== 32'h0000_0000 || bus.LO !== 32'h8000_0000) begin
      errors++;
      $display("FAIL div_ovf_const: HI=%h LO=%h required 00000000 80000000", bus.HI, bus.LO);
    end
    issue(3'd2, 32'd7, 32'hFFFF_FFFE);
    wait_done(DC, "div_negdivisor");
    issue(3'd2, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
    wait_done(DC, "div_bothneg");
    issue(3'd2, 32'd5, 32'd0);
    wait_done(DC, "div_zero");
    issue(3'd3, 32'hFFFF_FFFF, 32'd16);
    wait_done(DC, "divu");
    for (int i = 0; i < 4; i++) begin
      issue(3'(2 + i % 2), $urandom, $urandom_range(1, 32'hFFFF));
      wait_done(DC, "div_rand");
    end
  endtask

  task automatic test_move();
    issue(3'd4, 32'h1234_5678, 32'd0);
    checks++;
    if (bus.HI !== 32'h1234_5678 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mthi: HI=%h busy=%b required 12345678 0", bus.HI, bus.busy);
    end
    issue(3'd5, 32'hCAFE_0001, 32'd0);
    checks++;
    if (bus.LO !== m_lo || bus.HI !== m_hi || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL mtlo: HI=%h LO=%h busy=%b required %h %h 0", bus.HI, bus.LO, bus.busy,
               m_hi, m_lo);
    end
    for (int i = 6; i < 8; i++) begin
      bus.start = 1'b1;
      bus.op    = 3'(i);
      bus.A     = 32'hDEAD_BEEF;
      tick();
      bus.start = 1'b0;
      checks++;
      if (bus.HI !== m_hi || bus.LO !== m_lo || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL reserved_op%0d: HI=%h LO=%h busy=%b required %h %h 0", i, bus.HI, bus.LO,
                 bus.busy, m_hi, m_lo);
      end
    end
    // MTLO arriving mid-multiply must be dropped.
    issue(3'd0, 32'd3, 32'd4);
    bus.start = 1'b1;
    bus.op    = 3'd5;
    bus.A     = 32'h0000_0001;
    tick();
    bus.start = 1'b0;
    wait_done(MC - 1, "mtlo_during_mult");
    checks++;
    if (bus.LO !== 32'd12 || bus.HI !== 32'd0) begin
      errors++;
      $display("FAIL mtlo_during_mult_const: HI=%h LO=%h required 00000000 0000000C",
               bus.HI, bus.LO);
    end
  endtask

  task automatic test_reset_abort();
    issue(3'd2, 32'd100, 32'd7);
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
      errors++;
      $display("FAIL abort_reset: busy=%b HI=%h LO=%h required 0 0 0", bus.busy, bus.HI, bus.LO);
    end
    scb.delete();
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
        errors++;
        $display("FAIL abort_late_write: busy=%b HI=%h LO=%h required 0 0 0",
                 bus.busy, bus.HI, bus.LO);
      end
    end
    issue(3'd0, 32'd6, 32'd7);
    wait_done(MC, "mult_after_reset");
  endtask

  task automatic test_back_to_back();
    issue(3'd2, 32'd1000, 32'd7);
    bus.start = 1'b1;
    bus.op    = 3'd0;
    bus.A     = 32'd6;
    bus.B     = 32'd7;
    wait_done(DC, "div_under_mult_spam");
    // start still held: the first idle edge must accept the waiting MULT.
    model_push(3'd0, 32'd6, 32'd7);
    tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_accept: busy=%b required 1", bus.busy);
    end
    wait_done(MC, "b2b_mult");
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_move();
    test_reset_abort();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
